sys_ctrl_tx: RTL and testbench

//  Response-path controller. Captures register-file read data (1 byte) and ALU results (2 bytes).

---
 rtl/sys_ctrl_tx.sv | 161 ++++++++++++++++
 tb/tb_sys_ctrl_tx.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_ctrl_tx.sv
// Response-path controller: queues RF read bytes and ALU results and serialises them into the UART TX.
// Latency: RF valid pulse at edge n gives a TX strobe at edge n+2 when the UART is idle.
// Backpressure: waits on UART_TX_BUSY per byte; two capture slots, a third response is dropped and flagged.
module sys_ctrl_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   RF_RdData,
    input  logic                    RF_RdData_VLD,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    ALU_OUT_VLD,
    input  logic                    UART_TX_BUSY,
    output logic [DATA_WIDTH-1:0]   UART_TX_DATA,
    output logic                    UART_TX_VLD,
    output logic                    OVERFLOW
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t state;
    logic   byte_idx;

    // Capture slots: the active one is being transmitted, pending is one deep behind it.
    logic                    act_vld;
    logic                    act_two;
    logic [2*DATA_WIDTH-1:0] act_dat;
    logic                    pnd_vld;
    logic                    pnd_two;
    logic [2*DATA_WIDTH-1:0] pnd_dat;

    logic                    nxt_act_vld;
    logic                    nxt_act_two;
    logic [2*DATA_WIDTH-1:0] nxt_act_dat;
    logic                    nxt_pnd_vld;
    logic                    nxt_pnd_two;
    logic [2*DATA_WIDTH-1:0] nxt_pnd_dat;
    logic                    drop;
    logic                    finish;

    // The last byte of the active response has completed its frame on this edge.
    assign finish = (state == WAIT_DONE) && !UART_TX_BUSY && (byte_idx || !act_two);

    // Promote pending first, then place new responses; RF is offered a slot before ALU.
    always_comb begin
        nxt_act_vld = act_vld;
        nxt_act_two = act_two;
        nxt_act_dat = act_dat;
        nxt_pnd_vld = pnd_vld;
        nxt_pnd_two = pnd_two;
        nxt_pnd_dat = pnd_dat;
        drop        = 1'b0;
        if (finish) begin
            nxt_act_vld = pnd_vld;
            nxt_act_two = pnd_two;
            nxt_act_dat = pnd_dat;
            nxt_pnd_vld = 1'b0;
        end
        if (RF_RdData_VLD) begin
            if (!nxt_act_vld) begin
                nxt_act_vld = 1'b1;
                nxt_act_two = 1'b0;
                nxt_act_dat = {{DATA_WIDTH{1'b0}}, RF_RdData};
            end else if (!nxt_pnd_vld) begin
                nxt_pnd_vld = 1'b1;
                nxt_pnd_two = 1'b0;
                nxt_pnd_dat = {{DATA_WIDTH{1'b0}}, RF_RdData};
            end else begin
                drop = 1'b1;
            end
        end
        if (ALU_OUT_VLD) begin
            if (!nxt_act_vld) begin
                nxt_act_vld = 1'b1;
                nxt_act_two = 1'b1;
                nxt_act_dat = ALU_OUT;
            end else if (!nxt_pnd_vld) begin
                nxt_pnd_vld = 1'b1;
                nxt_pnd_two = 1'b1;
                nxt_pnd_dat = ALU_OUT;
            end else begin
                drop = 1'b1;
            end
        end
    end

    // Slot registers and the sticky overflow flag.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            act_vld  <= 1'b0;
            act_two  <= 1'b0;
            act_dat  <= '0;
            pnd_vld  <= 1'b0;
            pnd_two  <= 1'b0;
            pnd_dat  <= '0;
            OVERFLOW <= 1'b0;
        end else begin
            act_vld  <= nxt_act_vld;
            act_two  <= nxt_act_two;
            act_dat  <= nxt_act_dat;
            pnd_vld  <= nxt_pnd_vld;
            pnd_two  <= nxt_pnd_two;
            pnd_dat  <= nxt_pnd_dat;
            OVERFLOW <= OVERFLOW | drop;
        end
    end

    // Byte sequencer: strobe one byte, wait for the UART to take it and finish the frame.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= IDLE;
            byte_idx     <= 1'b0;
            UART_TX_DATA <= '0;
            UART_TX_VLD  <= 1'b0;
        end else begin
            UART_TX_VLD <= 1'b0;
            case (state)
                IDLE: begin
                    byte_idx <= 1'b0;
                    if (act_vld) begin
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (!UART_TX_BUSY) begin
                        UART_TX_DATA <= byte_idx ? act_dat[2*DATA_WIDTH-1:DATA_WIDTH]
                                                 : act_dat[DATA_WIDTH-1:0];
                        UART_TX_VLD  <= 1'b1;
                        state        <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (UART_TX_BUSY) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!UART_TX_BUSY) begin
                        if (!byte_idx && act_two) begin
                            byte_idx <= 1'b1;
                            state    <= SEND;
                        end else begin
                            byte_idx <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end
                default: begin
                    byte_idx <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sys_ctrl_tx.sv
// Bench for sys_ctrl_tx: a UART TX model answers strobes with BUSY frames and a monitor logs every strobe.
// Expected byte streams come from a response-level model (RF -> 1 byte, ALU -> low then high byte).
// Scenarios run in sequence; every wait is bounded by a cycle budget.
module tb_sys_ctrl_tx;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  RF_RdData = '0;
    logic        RF_RdData_VLD = 1'b0;
    logic [15:0] ALU_OUT = '0;
    logic        ALU_OUT_VLD = 1'b0;
    logic        UART_TX_BUSY;
    logic [7:0]  UART_TX_DATA;
    logic        UART_TX_VLD;
    logic        OVERFLOW;

    int total = 0;
    int bad   = 0;

    sys_ctrl_tx #(.DATA_WIDTH(8)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .RF_RdData     (RF_RdData),
        .RF_RdData_VLD (RF_RdData_VLD),
        .ALU_OUT       (ALU_OUT),
        .ALU_OUT_VLD   (ALU_OUT_VLD),
        .UART_TX_BUSY  (UART_TX_BUSY),
        .UART_TX_DATA  (UART_TX_DATA),
        .UART_TX_VLD   (UART_TX_VLD),
        .OVERFLOW      (OVERFLOW)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // UART TX model and strobe monitor, both evaluated on the falling edge.
    int   flen       = 10;
    int   frame_left = 0;
    logic force_busy = 1'b0;
    int   fall_cyc   = 0;
    int   viol       = 0;
    logic prev_vld   = 1'b0;
    logic [7:0] last_dat = '0;
    logic [7:0] got_dat[$];
    int         got_cyc[$];
    int         got_fall[$];

    assign UART_TX_BUSY = (frame_left != 0) || force_busy;

    always @(negedge CLK) begin
        if (UART_TX_VLD) begin
            got_dat.push_back(UART_TX_DATA);
            got_cyc.push_back(cyc);
            got_fall.push_back(fall_cyc);
            if (UART_TX_BUSY || prev_vld) viol++;
        end else if (RST && UART_TX_DATA !== last_dat) begin
            viol++;
        end
        last_dat = UART_TX_DATA;
        prev_vld = UART_TX_VLD;
        if (frame_left > 0) begin
            frame_left--;
            if (frame_left == 0) fall_cyc = cyc;
        end
        if (UART_TX_VLD) frame_left = flen;
    end

    int vld_edge;

    task automatic pulse(input logic rf, input logic alu, input logic [7:0] rd, input logic [15:0] ad);
        @(negedge CLK);
        RF_RdData     = rd;
        ALU_OUT       = ad;
        RF_RdData_VLD = rf;
        ALU_OUT_VLD   = alu;
        vld_edge      = cyc + 1;
        @(negedge CLK);
        RF_RdData_VLD = 1'b0;
        ALU_OUT_VLD   = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int budget, input string name);
        int k = 0;
        while (got_dat.size() < n && k < budget) begin
            @(negedge CLK);
            k++;
        end
        #1;
        total++;
        if (got_dat.size() < n) begin
            bad++;
            $display("FAIL %s: timeout, strobes seen=%0d required=%0d", name, got_dat.size(), n);
        end
    endtask

    task automatic pop_strobe(output logic [7:0] d, output int c, output int f);
        if (got_dat.size() > 0) begin
            d = got_dat.pop_front();
            c = got_cyc.pop_front();
            f = got_fall.pop_front();
        end else begin
            d = 8'hxx;
            c = -1;
            f = -1;
        end
    endtask

    // Quiet means BUSY low long enough that no queued byte can still be on its way.
    task automatic wait_idle();
        int k = 0;
        int low = 0;
        while (low < 8 && k < 2000) begin
            @(negedge CLK);
            k++;
            low = UART_TX_BUSY ? 0 : low + 1;
        end
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        total += 3;
        if (UART_TX_VLD !== 1'b0) begin bad++; $display("FAIL reset_vld: got %b want 0", UART_TX_VLD); end
        if (UART_TX_DATA !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", UART_TX_DATA); end
        if (OVERFLOW !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", OVERFLOW); end
        RST = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_rf_single();
        logic [7:0] d; int c, f;
        flen = 10;
        pulse(1'b1, 1'b0, 8'h5A, 16'h0);
        wait_bytes(1, 50, "rf_single");
        pop_strobe(d, c, f);
        total += 3;
        if (d !== 8'h5A) begin bad++; $display("FAIL rf_data: got %h want 5a", d); end
        if (c !== vld_edge + 2) begin bad++; $display("FAIL rf_latency: got edge %0d want %0d", c, vld_edge + 2); end
        if (OVERFLOW !== 1'b0) begin bad++; $display("FAIL rf_ovf: got %b want 0", OVERFLOW); end
        wait_idle();
    endtask

    task automatic test_alu();
        logic [7:0] d0, d1; int c0, c1, f0, f1;
        pulse(1'b0, 1'b1, 8'h00, 16'hBEEF);
        wait_bytes(2, 100, "alu");
        pop_strobe(d0, c0, f0);
        pop_strobe(d1, c1, f1);
        total += 3;
        if (d0 !== 8'hEF) begin bad++; $display("FAIL alu_lo: got %h want ef", d0); end
        if (d1 !== 8'hBE) begin bad++; $display("FAIL alu_hi: got %h want be", d1); end
        if (!(f1 > c0 && c1 == f1 + 2)) begin
            bad++; $display("FAIL alu_hi_timing: strobe %0d busy fell %0d lo strobe %0d", c1, f1, c0);
        end
        wait_idle();
    endtask

    task automatic test_same_cycle();
        logic [7:0] d; int c, f;
        logic [7:0] exp [3];
        exp[0] = 8'h11; exp[1] = 8'h33; exp[2] = 8'h22;
        pulse(1'b1, 1'b1, 8'h11, 16'h2233);
        wait_bytes(3, 150, "same_cycle");
        for (int i = 0; i < 3; i++) begin
            pop_strobe(d, c, f);
            total++;
            if (d !== exp[i]) begin bad++; $display("FAIL same_cycle_b%0d: got %h want %h", i, d, exp[i]); end
        end
        total++;
        if (OVERFLOW !== 1'b0) begin bad++; $display("FAIL same_cycle_ovf: got %b want 0", OVERFLOW); end
        wait_idle();
    endtask

    task automatic test_random();
        logic [7:0]  exp[$];
        logic [7:0]  d, rd;
        logic [15:0] ad;
        int c, f, kind;
        for (int it = 0; it < 20; it++) begin
            flen = $urandom_range(2, 12);
            kind = $urandom_range(0, 2);
            rd   = 8'($urandom);
            ad   = 16'($urandom);
            exp.delete();
            if (kind != 1) exp.push_back(rd);
            if (kind != 0) begin exp.push_back(ad[7:0]); exp.push_back(ad[15:8]); end
            pulse(kind != 1, kind != 0, rd, ad);
            wait_bytes(exp.size(), 200, "random");
            foreach (exp[i]) begin
                pop_strobe(d, c, f);
                total++;
                if (d !== exp[i]) begin bad++; $display("FAIL random_it%0d_b%0d: got %h want %h", it, i, d, exp[i]); end
            end
            wait_idle();
            total++;
            if (got_dat.size() != 0 || OVERFLOW !== 1'b0) begin
                bad++; $display("FAIL random_it%0d_extra: extra=%0d ovf=%b want 0/0", it, got_dat.size(), OVERFLOW);
            end
        end
    endtask

    task automatic test_busy_hold();
        logic [7:0] d; int c, f;
        flen = 6;
        force_busy = 1'b1;
        pulse(1'b1, 1'b0, 8'hC3, 16'h0);
        repeat (20) @(negedge CLK);
        total++;
        if (got_dat.size() != 0) begin bad++; $display("FAIL busy_hold_early: strobes %0d want 0", got_dat.size()); end
        force_busy = 1'b0;
        wait_bytes(1, 20, "busy_hold");
        pop_strobe(d, c, f);
        total++;
        if (d !== 8'hC3) begin bad++; $display("FAIL busy_hold_data: got %h want c3", d); end
        wait_idle();
    endtask

    task automatic test_overflow();
        logic [7:0] d; int c, f;
        flen = 10;
        pulse(1'b1, 1'b0, 8'h01, 16'h0);
        wait_bytes(1, 50, "ovf_first");
        pulse(1'b1, 1'b0, 8'h02, 16'h0);
        pulse(1'b1, 1'b0, 8'h03, 16'h0);
        @(negedge CLK);
        total++;
        if (OVERFLOW !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", OVERFLOW); end
        wait_bytes(2, 100, "ovf_second");
        pop_strobe(d, c, f);
        total++;
        if (d !== 8'h01) begin bad++; $display("FAIL ovf_b0: got %h want 01", d); end
        pop_strobe(d, c, f);
        total++;
        if (d !== 8'h02) begin bad++; $display("FAIL ovf_b1: got %h want 02", d); end
        wait_idle();
        repeat (10) @(negedge CLK);
        total += 2;
        if (got_dat.size() != 0) begin bad++; $display("FAIL ovf_dropped: extra strobes %0d want 0", got_dat.size()); end
        if (OVERFLOW !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", OVERFLOW); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d; int c, f;
        flen = 10;
        pulse(1'b0, 1'b1, 8'h00, 16'hABCD);
        wait_bytes(1, 50, "rstmid_lo");
        repeat (3) @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        total += 3;
        if (UART_TX_VLD !== 1'b0) begin bad++; $display("FAIL rstmid_vld: got %b want 0", UART_TX_VLD); end
        if (UART_TX_DATA !== 8'h00) begin bad++; $display("FAIL rstmid_data: got %h want 00", UART_TX_DATA); end
        if (OVERFLOW !== 1'b0) begin bad++; $display("FAIL rstmid_ovf: got %b want 0", OVERFLOW); end
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        repeat (30) @(negedge CLK);
        pop_strobe(d, c, f);
        total += 2;
        if (d !== 8'hCD) begin bad++; $display("FAIL rstmid_lo_data: got %h want cd", d); end
        if (got_dat.size() != 0) begin bad++; $display("FAIL rstmid_no_hi: extra strobes %0d want 0", got_dat.size()); end
        pulse(1'b1, 1'b0, 8'h77, 16'h0);
        wait_bytes(1, 50, "rstmid_after");
        pop_strobe(d, c, f);
        total += 2;
        if (d !== 8'h77) begin bad++; $display("FAIL rstmid_next_data: got %h want 77", d); end
        if (c !== vld_edge + 2) begin bad++; $display("FAIL rstmid_next_lat: got edge %0d want %0d", c, vld_edge + 2); end
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_rf_single();
        test_alu();
        test_same_cycle();
        test_random();
        test_busy_hold();
        test_overflow();
        test_reset_mid();
        total++;
        if (viol != 0) begin bad++; $display("FAIL strobe_rules: violations=%0d want 0", viol); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
